// File: rtl/mem_stage3.sv
// mem_stage3: stage-3 memory access; passes ALU ops through, runs loads/stores over req/ack with timeout
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   in_valid/in_ready                 handshake from execute (ready only in IDLE)
//   in_instr, in_alu, in_store_data   instruction, ALU result / address, store operand
//   dmem_req/we/addr/wdata            registered data-memory request, held until ack or timeout
//   dmem_ack, dmem_rdata              completion strobe and load data, same cycle
//   wb_valid, wb_instr, wb_from_calc,
//   wb_read, mem_err                  registered retire bundle for writeback; bubble when idle
module mem_stage3 #(
    parameter int          TIMEOUT      = 255,
    parameter int          TIMEOUT_W    = 8,
    parameter logic [15:0] BUBBLE_INSTR = 16'hC0F0,
    parameter logic [15:0] ERR_DATA     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_alu,
    input  logic [15:0] in_store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        wb_valid,
    output logic [15:0] wb_instr,
    output logic [15:0] wb_from_calc,
    output logic [15:0] wb_read,
    output logic        mem_err
);
    typedef enum logic {IDLE, REQ} state_t;
    localparam logic [TIMEOUT_W-1:0] TMO = TIMEOUT_W'(TIMEOUT);
    state_t               state;
    logic [15:0]          instr_q;
    logic [TIMEOUT_W-1:0] cnt;
    logic                 in_ld, in_st, q_ld, timed_out;
    assign in_ld     = in_instr[15:14] == 2'b01;
    assign in_st     = in_instr[15:11] == 5'b10001;
    assign q_ld      = instr_q[15:14] == 2'b01;
    assign in_ready  = state == IDLE;
    // cnt holds the number of the current REQ cycle (1-based); ack beats timeout
    assign timed_out = !dmem_ack && cnt == TMO;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            instr_q      <= BUBBLE_INSTR;
            cnt          <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_instr     <= BUBBLE_INSTR;
            wb_from_calc <= '0;
            wb_read      <= '0;
            mem_err      <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_instr     <= BUBBLE_INSTR;
            wb_from_calc <= '0;
            wb_read      <= '0;
            mem_err      <= 1'b0;
            if (state == IDLE) begin
                if (in_valid && (in_ld || in_st)) begin
                    state      <= REQ;
                    instr_q    <= in_instr;
                    dmem_addr  <= in_alu;
                    dmem_wdata <= in_store_data;
                    dmem_req   <= 1'b1;
                    dmem_we    <= in_st;
                    cnt        <= TIMEOUT_W'(1);
                end else if (in_valid) begin
                    wb_valid     <= 1'b1;
                    wb_instr     <= in_instr;
                    wb_from_calc <= in_alu;
                end
            end else if (dmem_ack || timed_out) begin
                state        <= IDLE;
                dmem_req     <= 1'b0;
                dmem_we      <= 1'b0;
                wb_valid     <= 1'b1;
                wb_instr     <= instr_q;
                wb_from_calc <= dmem_addr;
                wb_read      <= !q_ld ? 16'h0000 : dmem_ack ? dmem_rdata : ERR_DATA;
                mem_err      <= !dmem_ack;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
